// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a byte stream of COUNT, big-endian words
// and a trailing XOR checksum, writes the words to imem and releases the CPU on success.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest word count that still fits between BASE_ADDR and the top of imem.
  localparam logic [16:0]           LIMIT = 17'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

  state_t r_state;
  state_t w_next;

  logic [7:0]            r_countHi;
  logic [15:0]           r_count;
  logic [1:0]            r_byteIdx;
  logic [15:0]           r_wordIdx;
  logic [7:0]            r_acc;
  logic [23:0]           r_word;
  logic                  r_wrEn;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [31:0]           r_wrData;
  logic                  r_cpuHold;
  logic                  r_done;
  logic                  r_err;

  logic        w_accept;
  logic [15:0] w_count;
  logic        w_hdrTooBig;
  logic        w_wordDone;
  logic        w_lastWord;

  assign w_accept    = in_valid & in_ready;
  assign w_count     = {r_countHi, in_data};
  assign w_hdrTooBig = {1'b0, w_count} > LIMIT;
  assign w_wordDone  = (r_byteIdx == 2'd3);
  assign w_lastWord  = (r_wordIdx == (r_count - 16'd1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_HDR_HI;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (w_accept) w_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (w_hdrTooBig)           w_next = S_ERR;
          else if (w_count == 16'd0) w_next = S_CHK;
          else                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (w_accept && w_wordDone && w_lastWord) w_next = S_CHK;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (w_accept) w_next = (in_data == r_acc) ? S_DONE : S_ERR;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // Status flags track the next state so they rise together with the terminal state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_countHi <= 8'd0;
      r_count   <= 16'd0;
      r_byteIdx <= 2'd0;
      r_wordIdx <= 16'd0;
      r_acc     <= 8'd0;
      r_word    <= 24'd0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= BASE;
      r_wrData  <= 32'd0;
      r_cpuHold <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wrEn    <= 1'b0;
      r_cpuHold <= (w_next != S_DONE);
      r_done    <= (w_next == S_DONE);
      r_err     <= (w_next == S_ERR);
      if (w_accept && (r_state != S_CHK)) begin
        r_acc <= r_acc ^ in_data;
      end
      if (w_accept) begin
        case (r_state)
          S_HDR_HI: r_countHi <= in_data;
          S_HDR_LO: r_count   <= w_count;
          S_DATA: begin
            r_word    <= {r_word[15:0], in_data};
            r_byteIdx <= r_byteIdx + 2'd1;
            if (w_wordDone) begin
              r_wrEn    <= 1'b1;
              r_wrData  <= {r_word, in_data};
              r_wrAddr  <= BASE + r_wordIdx[ADDR_WIDTH-1:0];
              r_wordIdx <= r_wordIdx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en    = r_wrEn;
  assign wr_addr  = r_wrAddr;
  assign wr_data  = r_wrData;
  assign cpu_hold = r_cpuHold;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0 and base F0) share one byte
// stream and are compared against an image-level model of the expected writes and status.
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] inData;
  logic       inValid;

  logic       inReady0, wrEn0, cpuHold0, done0, err0;
  logic [7:0] wrAddr0;
  logic [31:0] wrData0;
  logic       inReady1, wrEn1, cpuHold1, done1, err1;
  logic [7:0] wrAddr1;
  logic [31:0] wrData1;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
    .clock(clock), .reset(reset), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady0), .wr_en(wrEn0), .wr_addr(wrAddr0), .wr_data(wrData0),
    .cpu_hold(cpuHold0), .done(done0), .err(err0)
  );

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(240)) dut1 (
    .clock(clock), .reset(reset), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady1), .wr_en(wrEn1), .wr_addr(wrAddr1), .wr_data(wrData1),
    .cpu_hold(cpuHold1), .done(done1), .err(err1)
  );

  typedef struct {
    int addr;
    int data;
    int idx;
  } wr_t;

  wr_t        got0[$];
  wr_t        got1[$];
  logic [7:0] stim[$];
  int         sentCount;
  int         testsRun;
  int         testsFailed;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Each write is tagged with how many bytes had been accepted, to pin its latency.
  always @(negedge clock) begin
    wr_t w;
    if (wrEn0) begin
      w.addr = int'(wrAddr0); w.data = int'(wrData0); w.idx = sentCount;
      got0.push_back(w);
    end
    if (wrEn1) begin
      w.addr = int'(wrAddr1); w.data = int'(wrData1); w.idx = sentCount;
      got1.push_back(w);
    end
  end

  function automatic int baseOf(input int d);
    return (d == 0) ? 0 : 240;
  endfunction

  function automatic logic [31:0] getOut(input int d, input int which);
    logic [31:0] v;
    case (which)
      0: v = (d == 0) ? 32'(wrEn0)    : 32'(wrEn1);
      1: v = (d == 0) ? 32'(wrAddr0)  : 32'(wrAddr1);
      2: v = (d == 0) ? wrData0       : wrData1;
      3: v = (d == 0) ? 32'(cpuHold0) : 32'(cpuHold1);
      4: v = (d == 0) ? 32'(done0)    : 32'(done1);
      5: v = (d == 0) ? 32'(err0)     : 32'(err1);
      default: v = (d == 0) ? 32'(inReady0) : 32'(inReady1);
    endcase
    return v;
  endfunction

  function automatic int modelCount();
    return int'({stim[0], stim[1]});
  endfunction

  function automatic bit modelHdrErr(input int base);
    return modelCount() > (256 - base);
  endfunction

  function automatic logic [7:0] modelChk();
    logic [7:0] x = 8'd0;
    for (int i = 0; i < 2 + 4 * modelCount(); i++) x ^= stim[i];
    return x;
  endfunction

  function automatic int modelWord(input int i);
    return int'({stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
  endfunction

  function automatic int modelTerm(input int base);
    return modelHdrErr(base) ? 2 : 3 + 4 * modelCount();
  endfunction

  function automatic bit modelDone(input int base);
    if (modelHdrErr(base)) return 1'b0;
    return stim[2 + 4 * modelCount()] == modelChk();
  endfunction

  task automatic checkReset(input string name);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s/d%0d/rstWrEn", name, d),   getOut(d, 0), 32'd0);
      checkOutput($sformatf("%s/d%0d/rstWrAddr", name, d), getOut(d, 1), 32'(baseOf(d)));
      checkOutput($sformatf("%s/d%0d/rstWrData", name, d), getOut(d, 2), 32'd0);
      checkOutput($sformatf("%s/d%0d/rstHold", name, d),   getOut(d, 3), 32'd1);
      checkOutput($sformatf("%s/d%0d/rstDone", name, d),   getOut(d, 4), 32'd0);
      checkOutput($sformatf("%s/d%0d/rstErr", name, d),    getOut(d, 5), 32'd0);
      checkOutput($sformatf("%s/d%0d/rstReady", name, d),  getOut(d, 6), 32'd1);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset   = 1'b1;
    inValid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    got0.delete();
    got1.delete();
    sentCount = 0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapPct);
    while (int'($urandom_range(99)) < gapPct) begin
      @(negedge clock);
      inValid = 1'b0;
      inData  = 8'($urandom);
    end
    @(negedge clock);
    inData  = b;
    inValid = 1'b1;
    @(posedge clock);
    #1;
    sentCount++;
    inValid = 1'b0;
  endtask

  task automatic checkResults(input string name);
    wr_t got[$];
    int  expN;
    int  base;
    bit  expD;
    for (int d = 0; d < 2; d++) begin
      base = baseOf(d);
      expD = modelDone(base);
      expN = modelHdrErr(base) ? 0 : modelCount();
      if (d == 0) got = got0; else got = got1;
      checkOutput($sformatf("%s/d%0d/nWrites", name, d), 32'(got.size()), 32'(expN));
      for (int i = 0; i < expN && i < got.size(); i++) begin
        checkOutput($sformatf("%s/d%0d/addr%0d", name, d, i), 32'(got[i].addr), 32'(base + i));
        checkOutput($sformatf("%s/d%0d/data%0d", name, d, i), 32'(got[i].data), 32'(modelWord(i)));
        checkOutput($sformatf("%s/d%0d/lat%0d", name, d, i),  32'(got[i].idx),  32'(2 + 4 * (i + 1)));
      end
      checkOutput($sformatf("%s/d%0d/done", name, d),  getOut(d, 4), 32'(expD));
      checkOutput($sformatf("%s/d%0d/err", name, d),   getOut(d, 5), 32'(!expD));
      checkOutput($sformatf("%s/d%0d/hold", name, d),  getOut(d, 3), 32'(!expD));
      checkOutput($sformatf("%s/d%0d/ready", name, d), getOut(d, 6), 32'd0);
      checkOutput($sformatf("%s/d%0d/excl", name, d),  getOut(d, 4) & getOut(d, 5), 32'd0);
    end
  endtask

  // Sends the whole stream, checks status right before and right at termination, then resets.
  task automatic applyStimulus(input string name, input int gapPct);
    int term[2];
    bit expD[2];
    for (int d = 0; d < 2; d++) begin
      term[d] = modelTerm(baseOf(d));
      expD[d] = modelDone(baseOf(d));
    end
    for (int k = 0; k < stim.size(); k++) begin
      sendByte(stim[k], gapPct);
      for (int d = 0; d < 2; d++) begin
        if (sentCount == term[d] - 1) begin
          checkOutput($sformatf("%s/d%0d/preDone", name, d), getOut(d, 4), 32'd0);
          checkOutput($sformatf("%s/d%0d/preErr", name, d),  getOut(d, 5), 32'd0);
        end
        if (sentCount == term[d]) begin
          checkOutput($sformatf("%s/d%0d/termDone", name, d), getOut(d, 4), 32'(expD[d]));
          checkOutput($sformatf("%s/d%0d/termErr", name, d),  getOut(d, 5), 32'(!expD[d]));
        end
      end
    end
    repeat (3) @(negedge clock);
    checkResults(name);
    doReset();
    checkReset(name);
  endtask

  task automatic buildImage(input int cnt, input bit badChk);
    logic [7:0] x;
    stim.delete();
    stim.push_back(8'(cnt >> 8));
    stim.push_back(8'(cnt));
    for (int i = 0; i < 4 * cnt; i++) stim.push_back(8'($urandom));
    x = modelChk();
    if (badChk) x ^= 8'(1 + $urandom_range(254));
    stim.push_back(x);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    sentCount   = 0;
    reset       = 1'b1;
    inValid     = 1'b0;
    inData      = 8'd0;
    repeat (2) @(posedge clock);
    doReset();
    checkReset("init");

    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
    applyStimulus("case1", 0);

    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h29};
    applyStimulus("badChk", 0);

    stim = '{8'h00, 8'h00, 8'h00};
    applyStimulus("empty", 0);

    stim = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    applyStimulus("tooBig", 0);

    buildImage(256, 1'b0);
    applyStimulus("full256", 0);

    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
    applyStimulus("case1Gaps", 50);

    for (int k = 0; k < 4; k++) sendByte(stim[k], 0);
    repeat (3) @(negedge clock);
    checkOutput("partial/nWrites0", 32'(got0.size()), 32'd0);
    checkOutput("partial/nWrites1", 32'(got1.size()), 32'd0);
    doReset();
    checkReset("partial");
    applyStimulus("afterReset", 0);

    buildImage(17, 1'b0);
    applyStimulus("count11", 10);
    buildImage(16, 1'b0);
    applyStimulus("count10", 10);

    for (int r = 0; r < 10; r++) begin
      buildImage(int'($urandom_range(24)), ($urandom_range(3) == 0));
      applyStimulus($sformatf("rand%0d", r), int'($urandom_range(60)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
